// File: rtl/sample_limiter_if.sv
// ---------------------------------------------------------------------------
// sample_limiter_if
//   Bundles the sample handshake and result bus of sample_limiter.
//   The clock and reset stay as plain module ports.
//
//   i_Start          one-cycle strobe: the accumulated totals are valid
//   i_Sample_L/R     signed 32-bit even/odd harmonic totals
//   o_Sample_L/R     signed 16-bit limited samples, held until the next o_Valid
//   o_Valid          one-cycle strobe: o_Sample_L/R were updated
//   o_Busy           high from the cycle after an accepted i_Start through o_Valid
//   o_Clip           high if either channel saturated (held with the samples)
//   o_Shift          right-shift currently in force
//   o_Clip_Count     (only with SAMPLE_LIMITER_CLIP_COUNT_EN) clipped-sample count
//
//   slave  : seen from the limiter
//   master : seen from the block feeding it
// ---------------------------------------------------------------------------
interface sample_limiter_if;
  logic               i_Start;
  logic signed [31:0] i_Sample_L;
  logic signed [31:0] i_Sample_R;
  logic signed [15:0] o_Sample_L;
  logic signed [15:0] o_Sample_R;
  logic               o_Valid;
  logic               o_Busy;
  logic               o_Clip;
  logic [4:0]         o_Shift;
`ifdef SAMPLE_LIMITER_CLIP_COUNT_EN
  logic [15:0]        o_Clip_Count;
`endif

  modport slave (
    input  i_Start, i_Sample_L, i_Sample_R,
    output o_Sample_L, o_Sample_R, o_Valid, o_Busy, o_Clip, o_Shift
`ifdef SAMPLE_LIMITER_CLIP_COUNT_EN
    , output o_Clip_Count
`endif
  );

  modport master (
    output i_Start, i_Sample_L, i_Sample_R,
    input  o_Sample_L, o_Sample_R, o_Valid, o_Busy, o_Clip, o_Shift
`ifdef SAMPLE_LIMITER_CLIP_COUNT_EN
    , input o_Clip_Count
`endif
  );
endinterface

// File: rtl/sample_limiter.sv
// ---------------------------------------------------------------------------
// sample_limiter
//   Scales a pair of signed 32-bit harmonic totals down to 16-bit samples by
//   an adaptive arithmetic right shift, saturates them, and adjusts the shift:
//   a clipped sample raises the shift (less gain); PEAK_HOLD consecutive quiet
//   samples lower it (more gain), bounded to [SHIFT_MIN, SHIFT_MAX].
//
//   Pipeline, one state per clock: IDLE -> LATCH -> ABS -> SCALE -> SAT -> OUT.
//   o_Valid rises exactly 5 clocks after the accepted i_Start. New strobes
//   are accepted only in IDLE.
//
// Ports
//   i_Clock    single clock
//   i_Reset_n  synchronous reset, active low
//   bus        sample_limiter_if.slave (handshake, samples, status)
//
// Build option
//   SAMPLE_LIMITER_CLIP_COUNT_EN : adds bus.o_Clip_Count, a saturating count
//                                  of o_Valid strobes that carried o_Clip = 1.
// ---------------------------------------------------------------------------
module sample_limiter #(
  parameter int unsigned SHIFT_MIN   = 8,
  parameter int unsigned SHIFT_MAX   = 24,
  parameter int unsigned SHIFT_INIT  = 12,
  parameter logic [15:0] PEAK_HOLD   = 16'd4800,
  parameter logic [15:0] QUIET_LEVEL = 16'd8192
) (
  input logic             i_Clock,
  input logic             i_Reset_n,
  sample_limiter_if.slave bus
);

  localparam logic [4:0] SHIFT_MIN_W  = 5'(SHIFT_MIN);
  localparam logic [4:0] SHIFT_MAX_W  = 5'(SHIFT_MAX);
  localparam logic [4:0] SHIFT_INIT_W = 5'(SHIFT_INIT);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_ABS, S_SCALE, S_SAT, S_OUT
  } state_t;

  state_t state, state_next;

  // ---- state register --------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create ordering-dependent logic.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) state <= S_IDLE;
    else            state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.i_Start) state_next = S_LATCH;
      S_LATCH: state_next = S_ABS;
      S_ABS:   state_next = S_SCALE;
      S_SCALE: state_next = S_SAT;
      S_SAT:   state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---- datapath --------------------------------------------------------
  logic signed [31:0] lat_l, lat_r;     // captured totals
  logic [4:0]         lat_shift;        // shift used for this sample
  logic [31:0]        abs_l, abs_r;
  logic [31:0]        mag_peak;         // max(|L|, |R|)
  logic signed [31:0] scl_l, scl_r;     // floor(L / 2^shift)
  logic [31:0]        scl_peak;         // peak / 2^shift
  logic signed [15:0] sat_l, sat_r;
  logic               sat_clip;

  // Magnitudes as unsigned 32-bit: -2^31 negates to 32'h8000_0000 = 2^31.
  always_comb begin
    abs_l = lat_l[31] ? 32'(-lat_l) : 32'(lat_l);
    abs_r = lat_r[31] ? 32'(-lat_r) : 32'(lat_r);
  end

  function automatic logic signed [15:0] clamp16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'sd32767;
    else if (v < -32'sd32768) return -16'sd32768;
    else                      return v[15:0];
  endfunction

  function automatic logic out_of_range(input logic signed [31:0] v);
    return (v > 32'sd32767) || (v < -32'sd32768);
  endfunction

  // NOTE: pipeline registers carry no reset; each is written before it is
  // read for a given sample, and only the control state needs a known value.
  always_ff @(posedge i_Clock) begin
    // Capture on the accepting edge so later input changes cannot leak in.
    if (state == S_IDLE && bus.i_Start) begin
      lat_l     <= bus.i_Sample_L;
      lat_r     <= bus.i_Sample_R;
      lat_shift <= shift_q;
    end
    if (state == S_LATCH) mag_peak <= (abs_l > abs_r) ? abs_l : abs_r;
    if (state == S_ABS) begin
      scl_l    <= lat_l >>> lat_shift;
      scl_r    <= lat_r >>> lat_shift;
      scl_peak <= mag_peak >> lat_shift;
    end
    if (state == S_SCALE) begin
      sat_l    <= clamp16(scl_l);
      sat_r    <= clamp16(scl_r);
      sat_clip <= out_of_range(scl_l) || out_of_range(scl_r);
    end
  end

  // ---- outputs and gain control ------------------------------------------
  logic signed [15:0] out_l, out_r;
  logic               clip_q, valid_q, busy_q;
  logic [4:0]         shift_q, shift_next;
  logic [15:0]        quiet_q, quiet_next;

  // Gain decision made during OUT, from the sample just delivered.
  always_comb begin
    shift_next = shift_q;
    quiet_next = quiet_q;
    if (state == S_OUT) begin
      if (clip_q && shift_q < SHIFT_MAX_W) begin
        shift_next = shift_q + 5'd1;
        quiet_next = '0;
      end else if (scl_peak < {16'd0, QUIET_LEVEL}) begin
        if (({1'b0, quiet_q} + 17'd1) >= {1'b0, PEAK_HOLD}) begin
          quiet_next = '0;
          if (shift_q > SHIFT_MIN_W) shift_next = shift_q - 5'd1;
        end else begin
          quiet_next = quiet_q + 16'd1;
        end
      end else begin
        quiet_next = '0;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      out_l   <= '0;
      out_r   <= '0;
      clip_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      shift_q <= SHIFT_INIT_W;
      quiet_q <= '0;
    end else begin
      valid_q <= (state == S_SAT);
      busy_q  <= (state_next != S_IDLE);
      shift_q <= shift_next;
      quiet_q <= quiet_next;
      if (state == S_SAT) begin
        out_l  <= sat_l;
        out_r  <= sat_r;
        clip_q <= sat_clip;
      end
    end
  end

  assign bus.o_Sample_L = out_l;
  assign bus.o_Sample_R = out_r;
  assign bus.o_Clip     = clip_q;
  assign bus.o_Valid    = valid_q;
  assign bus.o_Busy     = busy_q;
  assign bus.o_Shift    = shift_q;

`ifdef SAMPLE_LIMITER_CLIP_COUNT_EN
  logic [15:0] clip_cnt_q;

  // Counted on the edge that loads the outputs, so it agrees with o_Clip.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n)
      clip_cnt_q <= '0;
    else if (state == S_SAT && sat_clip && clip_cnt_q != 16'hFFFF)
      clip_cnt_q <= clip_cnt_q + 16'd1;
  end

  assign bus.o_Clip_Count = clip_cnt_q;
`endif

endmodule

// File: tb/tb_sample_limiter.sv
// ---------------------------------------------------------------------------
// tb_sample_limiter
//   Randomised and directed stimulus for sample_limiter (PEAK_HOLD = 4),
//   checked against a behavioural model built from integer arithmetic.
// ---------------------------------------------------------------------------
module tb_sample_limiter;

  localparam int          SHIFT_MIN   = 8;
  localparam int          SHIFT_MAX   = 24;
  localparam int          SHIFT_INIT  = 12;
  localparam int          PEAK_HOLD   = 4;
  localparam int          QUIET_LEVEL = 8192;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sample_limiter_if bus ();

  sample_limiter #(
    .SHIFT_MIN   (SHIFT_MIN),
    .SHIFT_MAX   (SHIFT_MAX),
    .SHIFT_INIT  (SHIFT_INIT),
    .PEAK_HOLD   (16'(PEAK_HOLD)),
    .QUIET_LEVEL (16'(QUIET_LEVEL))
  ) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (bus.slave)
  );

  int n_checks   = 0;
  int n_failures = 0;

  task automatic check(input string tag, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // ---- reference model -------------------------------------------------
  int m_shift;
  int m_quiet;
  int m_clip_cnt;

  task automatic model_reset();
    m_shift    = SHIFT_INIT;
    m_quiet    = 0;
    m_clip_cnt = 0;
  endtask

  function automatic longint floor_div(input longint v, input longint d);
    longint q;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint iabs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint limit16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Expected results of one sample under the model's current shift.
  task automatic predict(input logic signed [31:0] l, input logic signed [31:0] r,
                         output longint el, output longint er,
                         output bit ec, output longint pk);
    longint d, ql, qr;
    d  = longint'(1) << m_shift;
    ql = floor_div(longint'(l), d);
    qr = floor_div(longint'(r), d);
    el = limit16(ql);
    er = limit16(qr);
    ec = (el != ql) || (er != qr);
    pk = ((iabs(longint'(l)) > iabs(longint'(r))) ? iabs(longint'(l)) : iabs(longint'(r))) / d;
  endtask

  task automatic model_gain(input bit clip, input longint pk);
    if (clip) m_clip_cnt = (m_clip_cnt < 65535) ? m_clip_cnt + 1 : 65535;
    if (clip && m_shift < SHIFT_MAX) begin
      m_shift++;
      m_quiet = 0;
    end else if (pk < QUIET_LEVEL) begin
      m_quiet++;
      if (m_quiet == PEAK_HOLD) begin
        if (m_shift > SHIFT_MIN) m_shift--;
        m_quiet = 0;
      end
    end else begin
      m_quiet = 0;
    end
  endtask

  task automatic check_outputs(input string tag, input longint el, input longint er, input bit ec);
    check({tag, "_l"},    longint'(bus.o_Sample_L), el);
    check({tag, "_r"},    longint'(bus.o_Sample_R), er);
    check({tag, "_clip"}, longint'(bus.o_Clip),     longint'(ec));
  endtask

  // One complete transaction from IDLE; inputs are scrambled after the strobe.
  task automatic run_sample(input logic signed [31:0] l, input logic signed [31:0] r);
    longint el, er, pk;
    bit     ec;
    int     lat;
    predict(l, r, el, er, ec, pk);
    @(negedge clk);
    bus.i_Start    = 1'b1;
    bus.i_Sample_L = l;
    bus.i_Sample_R = r;
    @(negedge clk);
    bus.i_Start    = 1'b0;
    bus.i_Sample_L = $urandom;
    bus.i_Sample_R = $urandom;
    lat = 1;
    check("busy_after_start", longint'(bus.o_Busy), 1);
    while (!bus.o_Valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 5);
    check_outputs("sample", el, er, ec);
    check("busy_at_valid", longint'(bus.o_Busy), 1);
    model_gain(ec, pk);
`ifdef SAMPLE_LIMITER_CLIP_COUNT_EN
    check("clip_count", longint'(bus.o_Clip_Count), m_clip_cnt);
`endif
    @(negedge clk);
    check("valid_one_cycle", longint'(bus.o_Valid), 0);
    check("busy_idle", longint'(bus.o_Busy), 0);
    check("shift", longint'(bus.o_Shift), m_shift);
  endtask

  function automatic logic signed [31:0] rand_total();
    logic signed [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0:       v = 32'sh8000_0000;
      1:       v = 32'sh7FFF_FFFF;
      2:       v = 32'sd0;
      default: v = v >>> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_l"},     longint'(bus.o_Sample_L), 0);
    check({tag, "_r"},     longint'(bus.o_Sample_R), 0);
    check({tag, "_valid"}, longint'(bus.o_Valid),    0);
    check({tag, "_busy"},  longint'(bus.o_Busy),     0);
    check({tag, "_clip"},  longint'(bus.o_Clip),     0);
    check({tag, "_shift"}, longint'(bus.o_Shift),    SHIFT_INIT);
`ifdef SAMPLE_LIMITER_CLIP_COUNT_EN
    check({tag, "_clip_count"}, longint'(bus.o_Clip_Count), 0);
`endif
  endtask

  initial begin
    longint ael, aer, apk, bel, ber, bpk;
    bit     aec, bec;
    int     nvalid, ghost, exp_shift;
    logic signed [31:0] a_l, a_r, b_l, b_r;

    rst_n          = 1'b0;
    bus.i_Start    = 1'b0;
    bus.i_Sample_L = '0;
    bus.i_Sample_R = '0;
    apply_reset(3);
    check_reset_values("reset");

    // Nominal scaling at the initial shift.
    run_sample(32'sh0001_0000, -32'sd131072);
    check("dir1_l", longint'(bus.o_Sample_L), 16);
    check("dir1_r", longint'(bus.o_Sample_R), -32);
    check("dir1_shift", longint'(bus.o_Shift), 12);

    // Both channels saturate, including the most negative total.
    run_sample(32'sh4000_0000, 32'sh8000_0000);
    check("dir2_l", longint'(bus.o_Sample_L), 32767);
    check("dir2_r", longint'(bus.o_Sample_R), -32768);
    check("dir2_clip", longint'(bus.o_Clip), 1);
    check("dir2_shift", longint'(bus.o_Shift), 13);
`ifdef SAMPLE_LIMITER_CLIP_COUNT_EN
    check("dir2_clip_count", longint'(bus.o_Clip_Count), 1);
`endif

    // Random traffic; clips drive the shift to SHIFT_MAX, quiet runs pull it back.
    for (int i = 0; i < 60; i++) run_sample(rand_total(), rand_total());

    // Quiet run: one step down per PEAK_HOLD samples, stopping at SHIFT_MIN.
    apply_reset(1);
    for (int i = 1; i <= 20; i++) begin
      run_sample(32'sd0, 32'sd0);
      exp_shift = SHIFT_INIT - i / PEAK_HOLD;
      if (exp_shift < SHIFT_MIN) exp_shift = SHIFT_MIN;
      check("quiet_shift", longint'(bus.o_Shift), exp_shift);
    end

    // Strobes on cycles 0, 2, 5 (only 0 accepted), then 6 (accepted).
    a_l = rand_total();
    a_r = rand_total();
    b_l = rand_total();
    b_r = rand_total();
    predict(a_l, a_r, ael, aer, aec, apk);
    nvalid = 0;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (bus.o_Valid) nvalid++;
      if (c == 2) check("burst_busy_c2", longint'(bus.o_Busy), 1);
      if (c == 5) begin
        check("burst_valid_c5", longint'(bus.o_Valid), 1);
        check_outputs("burst_a", ael, aer, aec);
        model_gain(aec, apk);
      end
      if (c == 6) begin
        check("burst_busy_c6", longint'(bus.o_Busy), 0);
        predict(b_l, b_r, bel, ber, bec, bpk);
      end
      if (c == 11) begin
        check("burst_valid_c11", longint'(bus.o_Valid), 1);
        check_outputs("burst_b", bel, ber, bec);
        model_gain(bec, bpk);
      end
      if (c == 12) check("burst_shift", longint'(bus.o_Shift), m_shift);
      bus.i_Start = (c == 0 || c == 2 || c == 5 || c == 6);
      if (c == 0)      begin bus.i_Sample_L = a_l; bus.i_Sample_R = a_r; end
      else if (c == 6) begin bus.i_Sample_L = b_l; bus.i_Sample_R = b_r; end
      else             begin bus.i_Sample_L = $urandom; bus.i_Sample_R = $urandom; end
    end
    check("burst_valid_count", nvalid, 2);
    bus.i_Start = 1'b0;

    // Reset pulse while the sample is in SCALE abandons it.
    run_sample(32'sh7FFF_FFFF, 32'sh0000_1234);
    @(negedge clk);
    bus.i_Start    = 1'b1;
    bus.i_Sample_L = 32'sh4000_0000;
    bus.i_Sample_R = 32'sh4000_0000;
    ghost = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.i_Start = 1'b0;
      if (bus.o_Valid) ghost++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_reset_values("abort");
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.o_Valid) ghost++;
    end
    check("abort_no_valid", ghost, 0);
    run_sample(32'sh0001_0000, -32'sd131072);
    for (int i = 0; i < 10; i++) run_sample(rand_total(), rand_total());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/sample_limiter.md
SAMPLE_LIMITER -- requirements
Module: sample_limiter

Interface
REQ-001 Param SHIFT_MIN, default 8: smallest allowed right-shift.
REQ-002 Param SHIFT_MAX, default 24: largest allowed right-shift.
REQ-003 Param SHIFT_INIT, default 12: shift loaded at reset.
REQ-004 Param PEAK_HOLD, default 16'd4800: number of consecutive quiet samples before gain is raised.
REQ-005 Param QUIET_LEVEL, default 16'd8192: scaled peak below this counts as quiet.
REQ-006 i_Clock  in  1  single clock for all logic; 48 MHz main clock.
REQ-007 i_Reset_n  in  1  synchronous reset, active-low.
REQ-008 i_Start  in  1  one-cycle strobe; accumulated totals are valid.
REQ-009 i_Sample_L  in  32  signed even-harmonic total.
REQ-010 i_Sample_R  in  32  signed odd-harmonic total.
REQ-011 o_Sample_L  out  16  signed limited left sample.
REQ-012 o_Sample_R  out  16  signed limited right sample.
REQ-013 o_Valid  out  1  one-cycle strobe; o_Sample_L/R updated; feeds the DAC sender start.
REQ-014 o_Busy  out  1  high from the cycle after an accepted i_Start until o_Valid, inclusive.
REQ-015 o_Clip  out  1  held with the outputs; high if either channel saturated.
REQ-016 o_Shift  out  5  shift currently in force.

Function
REQ-017 States: IDLE, LATCH, ABS, SCALE, SAT, OUT. Transitions: IDLE->LATCH on i_Start, then one state per clock, OUT->IDLE.
REQ-018 LATCH captures i_Sample_L/R and the current shift. Input changes after the i_Start cycle have no effect.
REQ-019 ABS computes unsigned 32-bit magnitudes; |-2^31| = 2^31 with no overflow. Peak = max(|L|, |R|).
REQ-020 SCALE computes an arithmetic right shift of each channel by the latched shift (floor rounding) and the peak shifted by the same amount.
REQ-021 SAT clamps each channel to [-32768, 32767]. Clip = either channel clamped.
REQ-022 OUT drives o_Sample_L/R, o_Clip and a one-cycle o_Valid. Latency from i_Start to o_Valid is exactly 5 clocks.
REQ-023 Outputs hold their value until the next o_Valid.
REQ-024 An i_Start while o_Busy is high is ignored and does not alter the in-flight sample. An i_Start in the OUT cycle is also ignored; it is accepted only in IDLE.
REQ-025 Gain update in OUT:
- Clip and shift < SHIFT_MAX: shift+1 and quiet counter cleared.
- Else if scaled peak < QUIET_LEVEL: quiet counter +1. When it reaches PEAK_HOLD, shift-1 (floor SHIFT_MIN) and counter cleared.
- Else: counter cleared.
REQ-026 The new shift applies from the next sample. The current sample always uses the shift latched in LATCH.
REQ-027 At the SHIFT_MAX or SHIFT_MIN bound the shift is unchanged, and the counter still clears as in REQ-025.

Reset
REQ-028 While i_Reset_n = 0 at a clock edge, the following take their reset values: state IDLE, o_Sample_L/R = 0, o_Valid = 0, o_Busy = 0, o_Clip = 0, o_Shift = SHIFT_INIT, quiet counter = 0.
REQ-029 Reset mid-operation abandons the sample. No o_Valid is produced for it.

Configuration
REQ-030 Macro SAMPLE_LIMITER_CLIP_COUNT_EN, when defined, adds output o_Clip_Count (16 bits).
- It increments on each o_Valid with o_Clip = 1 and saturates at 16'hFFFF.
- Reset value is 0.
REQ-031 Without SAMPLE_LIMITER_CLIP_COUNT_EN the port and counter are absent, and all other behaviour is identical.

Verification
REQ-032 Reset, then i_Start with L = 32'h0001_0000, R = -32'sd131072 -> o_Valid 5 clocks later, o_Sample_L = 16, o_Sample_R = -32, o_Clip = 0, o_Shift = 12.
REQ-033 i_Start with L = 32'h4000_0000, R = -32'sh8000_0000 -> o_Sample_L = 32767, o_Sample_R = -32768, o_Clip = 1, o_Shift = 13 after o_Valid. With SAMPLE_LIMITER_CLIP_COUNT_EN, o_Clip_Count = 1.
REQ-034 PEAK_HOLD = 4, shift 12, four samples of L = R = 0 -> o_Shift stays 12 after samples 1-3 and becomes 11 after sample 4. Repeat down to 8, then confirm a further 4 quiet samples keep it at 8.
REQ-035 i_Start pulsed on cycles 0, 2 and 5 relative to the first accepted strobe -> exactly one o_Valid (cycle 5) carrying cycle-0 data. A new strobe on cycle 6 is accepted.
REQ-036 i_Reset_n low for one clock during SCALE -> no o_Valid, all outputs at reset values, and the next i_Start completes normally in 5 clocks.
